// File: rtl/gol_pkg.sv
// Shared constants and the reader state encoding for the Game of Life board slice.
package gol_pkg;

    localparam int GOL_ROWS   = 16;
    localparam int GOL_COLS   = 16;
    localparam int GOL_CELLS  = GOL_ROWS * GOL_COLS;
    localparam int ROW_IDX_W  = $clog2(GOL_ROWS);
    localparam int LIVE_CNT_W = $clog2(GOL_CELLS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } reader_state_e;

endpackage

// File: rtl/board_row_reader_if.sv
// Row streaming channel: one board row plus its index per valid/ready transfer.
interface board_row_reader_if
    import gol_pkg::*;
#(
    parameter int ROWS = GOL_ROWS,
    parameter int COLS = GOL_COLS
);

    localparam int IDX_W = $clog2(ROWS);

    logic [COLS-1:0]  row_data;
    logic [IDX_W-1:0] row_idx;
    logic             row_valid;
    logic             row_ready;

    modport master (
        output row_data,
        output row_idx,
        output row_valid,
        input  row_ready
    );

    modport slave (
        input  row_data,
        input  row_idx,
        input  row_valid,
        output row_ready
    );

endinterface

// File: rtl/board_row_reader_popcount.sv
// Combinational population count of one board row.
module row_popcount #(
    parameter int COLS  = 16,
    parameter int CNT_W = $clog2(COLS + 1)
) (
    input  logic [COLS-1:0]  row,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < COLS; i++) begin
            count = count + CNT_W'(row[i]);
        end
    end

endmodule

// File: rtl/board_row_reader.sv
// Snapshots the live board on start and streams it out one row per handshake.
// Optional live-cell total on live_count when BOARD_READER_POPCOUNT_EN is defined.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; snapshot and counter hold
// SEND  | presenting snapshot row[row_cnt]; advance on handshake
// DONE  | one-cycle frame_done pulse, then back to IDLE
module board_row_reader
    import gol_pkg::*;
#(
    parameter int ROWS = GOL_ROWS,
    parameter int COLS = GOL_COLS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [ROWS*COLS-1:0]              board_i,
    output logic                              busy,
    output logic                              frame_done,
`ifdef BOARD_READER_POPCOUNT_EN
    output logic [$clog2(ROWS*COLS+1)-1:0]    live_count,
`endif
    board_row_reader_if.master                row_if
);

    localparam int IDX_W = $clog2(ROWS);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

    reader_state_e         state, state_nxt;
    logic [IDX_W-1:0]      row_cnt, row_cnt_nxt;
    logic [ROWS*COLS-1:0]  snapshot;
    logic [COLS-1:0]       snap_row;
    logic                  capture;
    logic                  row_valid;
    logic                  handshake;

    assign snap_row  = snapshot[int'(row_cnt)*COLS +: COLS];
    assign handshake = row_valid && row_if.row_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            row_cnt  <= '0;
            snapshot <= '0;
        end else begin
            state   <= state_nxt;
            row_cnt <= row_cnt_nxt;
            if (capture) begin
                snapshot <= board_i;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        capture     = 1'b0;
        row_valid   = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture     = 1'b1;
                    row_cnt_nxt = '0;
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                row_valid = 1'b1;
                if (row_if.row_ready) begin
                    // last row ends the frame; the counter never wraps to 0 here
                    if (row_cnt == LAST_ROW) begin
                        state_nxt = DONE;
                    end else begin
                        row_cnt_nxt = row_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy             = (state != IDLE);
    assign row_if.row_valid = row_valid;
    assign row_if.row_data  = row_valid ? snap_row : '0;
    assign row_if.row_idx   = row_valid ? row_cnt  : '0;

`ifdef BOARD_READER_POPCOUNT_EN
    localparam int PC_W = $clog2(COLS + 1);
    localparam int LC_W = $clog2(ROWS*COLS + 1);

    logic [PC_W-1:0] row_pop;
    logic [LC_W-1:0] live_cnt;

    row_popcount #(
        .COLS (COLS)
    ) u_row_popcount (
        .row   (snap_row),
        .count (row_pop)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_cnt <= '0;
        end else if (capture) begin
            live_cnt <= '0;
        end else if (handshake) begin
            live_cnt <= live_cnt + LC_W'(row_pop);
        end
    end

    assign live_count = live_cnt;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_board_row_reader.sv
// Directed bench for board_row_reader: table-driven frames plus hand-written corner sequences.
module tb_board_row_reader;
    import gol_pkg::*;

    logic           clk;
    logic           reset;
    logic           start;
    logic [255:0]   board_i;
    logic           busy;
    logic           frame_done;
`ifdef BOARD_READER_POPCOUNT_EN
    logic [8:0]     live_count;
`endif

    board_row_reader_if #(.ROWS(16), .COLS(16)) rif ();

    board_row_reader #(.ROWS(16), .COLS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .board_i    (board_i),
        .busy       (busy),
        .frame_done (frame_done),
`ifdef BOARD_READER_POPCOUNT_EN
        .live_count (live_count),
`endif
        .row_if     (rif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        ready;
        logic        valid;
        logic [3:0]  idx;
        logic [15:0] data;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vecs [64];
    int   nvec;
    int   checks;
    int   errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic r, input logic v, input logic [3:0] i,
                       input logic [15:0] d, input logic dn, input logic b);
        vecs[nvec] = '{s, r, v, i, d, dn, b};
        nvec++;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < nvec; i++) begin
            start         = vecs[i].start;
            rif.row_ready = vecs[i].ready;
            step();
            check($sformatf("%s[%0d].valid", tag, i), 32'(rif.row_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
                check($sformatf("%s[%0d].idx", tag, i), 32'(rif.row_idx), 32'(vecs[i].idx));
                check($sformatf("%s[%0d].data", tag, i), 32'(rif.row_data), 32'(vecs[i].data));
            end
            check($sformatf("%s[%0d].done", tag, i), 32'(frame_done), 32'(vecs[i].done));
            check($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(vecs[i].busy));
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!frame_done && n < 100) begin
            step();
            n++;
        end
        check({name, ".frame_done_seen"}, 32'(frame_done), 32'd1);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        start         = 1'b0;
        board_i       = '0;
        rif.row_ready = 1'b0;

        #12;
        check("rst.valid", 32'(rif.row_valid), 32'd0);
        check("rst.busy",  32'(busy),          32'd0);
        check("rst.done",  32'(frame_done),    32'd0);
        check("rst.data",  32'(rif.row_data),  32'd0);
        step();
        reset = 1'b1;
        step();

        // basic frame: row r = 1<<r, ready tied high
        for (int r = 0; r < 16; r++) board_i[r*16 +: 16] = 16'h0001 << r;
        nvec = 0;
        add(1, 1, 1, 4'd0, 16'h0001, 0, 1);
        for (int r = 1; r < 16; r++) add(0, 1, 1, 4'(r), 16'h0001 << r, 0, 1);
        add(0, 1, 0, 4'd0, 16'h0000, 1, 1);
        add(0, 1, 0, 4'd0, 16'h0000, 0, 0);
        run_table("basic");

        // backpressure at row 3 plus start pulses at rows 2, 15 and in DONE
        for (int r = 0; r < 16; r++) board_i[r*16 +: 16] = 16'h1111 * 16'(r);
        nvec = 0;
        add(1, 1, 1, 4'd0, 16'h0000, 0, 1);
        add(0, 1, 1, 4'd1, 16'h1111, 0, 1);
        add(0, 1, 1, 4'd2, 16'h2222, 0, 1);
        add(1, 1, 1, 4'd3, 16'h3333, 0, 1);
        for (int k = 0; k < 5; k++) add(0, 0, 1, 4'd3, 16'h3333, 0, 1);
        add(0, 1, 1, 4'd4, 16'h4444, 0, 1);
        for (int r = 5; r < 16; r++) add(0, 1, 1, 4'(r), 16'h1111 * 16'(r), 0, 1);
        add(1, 1, 0, 4'd0, 16'h0000, 1, 1);
        add(1, 1, 0, 4'd0, 16'h0000, 0, 0);
        add(0, 1, 0, 4'd0, 16'h0000, 0, 0);
        add(0, 1, 0, 4'd0, 16'h0000, 0, 0);
        run_table("bp");

        // snapshot isolation
        for (int r = 0; r < 16; r++) board_i[r*16 +: 16] = 16'hAAAA;
        start         = 1'b1;
        rif.row_ready = 1'b1;
        step();
        start   = 1'b0;
        board_i = '1;
        for (int r = 0; r < 16; r++) begin
            check($sformatf("iso.idx%0d", r),  32'(rif.row_idx),  32'(r));
            check($sformatf("iso.data%0d", r), 32'(rif.row_data), 32'h0000AAAA);
            step();
        end
        check("iso.done", 32'(frame_done), 32'd1);
        step();
        check("iso.idle", 32'(busy), 32'd0);

        // reset mid-frame at row 7
        for (int r = 0; r < 16; r++) board_i[r*16 +: 16] = 16'h0001 << r;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int r = 0; r < 7; r++) step();
        check("mid.idx7", 32'(rif.row_idx), 32'd7);
        reset = 1'b0;
        #1;
        check("mid.valid0", 32'(rif.row_valid), 32'd0);
        check("mid.busy0",  32'(busy),          32'd0);
        check("mid.data0",  32'(rif.row_data),  32'd0);
        check("mid.idx0",   32'(rif.row_idx),   32'd0);
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("mid.nodone%0d", k), 32'(frame_done), 32'd0);
            check($sformatf("mid.idle%0d", k),   32'(busy),       32'd0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        check("mid.restart.idx",  32'(rif.row_idx),  32'd0);
        check("mid.restart.data", 32'(rif.row_data), 32'h00000001);
        wait_done("mid.restart");
        step();

        // start held high re-triggers on the first IDLE cycle after DONE
        start = 1'b1;
        step();
        check("hold.row0", 32'(rif.row_valid), 32'd1);
        for (int r = 1; r < 16; r++) step();
        check("hold.row15", 32'(rif.row_idx), 32'd15);
        step();
        check("hold.done", 32'(frame_done), 32'd1);
        step();
        check("hold.idle", 32'(busy), 32'd0);
        step();
        check("hold.retrig.valid", 32'(rif.row_valid), 32'd1);
        check("hold.retrig.idx",   32'(rif.row_idx),   32'd0);
        start = 1'b0;
        wait_done("hold.retrig");
        step();

`ifdef BOARD_READER_POPCOUNT_EN
        board_i          = '0;
        board_i[15:0]    = 16'h0002;
        board_i[31:16]   = 16'h0004;
        board_i[47:32]   = 16'h0007;
        start = 1'b1;
        step();
        start = 1'b0;
        check("pop.clear", 32'(live_count), 32'd0);
        wait_done("pop.glider");
        check("pop.glider", 32'(live_count), 32'd5);
        step();
        check("pop.hold", 32'(live_count), 32'd5);
        board_i = '1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("pop.full");
        check("pop.full", 32'(live_count), 32'd256);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
